alu_op_scheduler: RTL and testbench

//  Shares one combinational 16-bit ALU (add/sub/mul/div/and/or, 3-bit op code) between two requesters.
//  - Arbitrates round-robin and registers operands so the ALU sees stable inputs for one full cycle.
//  - Captures out/hi/lo and returns a tagged response over a valid/ready handshake.
//  - Sits between the decode/issue stages and the shared ALU instance.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/alu_op_scheduler.sv | 130 +++++++++++++
 tb/tb_alu_op_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU op scheduler: op codes, FSM state encoding
// and default data widths.
package alu_sched_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_OP_WIDTH = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie, the requester that was not granted
// last wins. The grant history only moves forward when the caller accepts.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  // NOTE: the combinational output gets a default on entry, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  // Reset to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_grant <= 1'b1;
    else if (advance && |gnt)       last_grant <= gnt[1];
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one external combinational ALU between two requesters. It arbitrates,
// registers the operands and returns a tagged response over valid/ready.
// Optional feature macro: ALU_DIV_ZERO_TRAP_EN (trap unsigned divide by zero).
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_WIDTH = DEF_OP_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [WIDTH-1:0]    resp_result,
  output logic [WIDTH-1:0]    resp_hi,
  output logic                resp_err,
  output logic [WIDTH-1:0]    alu_in1,
  output logic [WIDTH-1:0]    alu_in2,
  output logic [OP_WIDTH-1:0] alu_con_sig,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic [WIDTH-1:0]    alu_hi,
  input  logic [WIDTH-1:0]    alu_lo,
  output logic                busy
);

`ifdef ALU_DIV_ZERO_TRAP_EN
  localparam bit DIV_TRAP = 1'b1;
`else
  localparam bit DIV_TRAP = 1'b0;
`endif

  state_t              state, state_next;
  logic [1:0]          gnt;
  logic                accept;
  logic [OP_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                id_q;
  logic                div_zero;

  assign accept = (state == IDLE) && (gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req0_ready = (state == IDLE) && gnt[0];
  assign req1_ready = (state == IDLE) && gnt[1];
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;

  assign div_zero    = DIV_TRAP && (op_q == OP_DIV) && (b_q == '0);
  assign alu_in1     = a_q;
  assign alu_in2     = div_zero ? WIDTH'(1) : b_q;
  assign alu_con_sig = op_q;

  // NOTE: asynchronous reset lives in the sensitivity list; sequential state
  // is always updated with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = EXEC;
      EXEC:                    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= gnt[1] ? req1_op : req0_op;
      a_q  <= gnt[1] ? req1_a  : req0_a;
      b_q  <= gnt[1] ? req1_b  : req0_b;
      id_q <= gnt[1];
    end
  end

  // Response fields only load at the end of EXEC, so they stay frozen in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result <= '0;
      resp_hi     <= '0;
      resp_err    <= 1'b0;
    end else if (state == EXEC) begin
      case (op_q)
        OP_MUL: begin
          resp_result <= alu_lo;
          resp_hi     <= alu_hi;
          resp_err    <= 1'b0;
        end
        OP_ADD, OP_SUB, OP_DIV, OP_AND, OP_OR: begin
          resp_result <= div_zero ? '1 : alu_out;
          resp_hi     <= '0;
          resp_err    <= div_zero;
        end
        default: begin
          resp_result <= '0;
          resp_hi     <= '0;
          resp_err    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: directed ops with hand-computed
// results, a behavioural ALU on the alu_* ports and a response monitor.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_result, resp_hi;
  logic [15:0] alu_in1, alu_in2, alu_out, alu_hi, alu_lo;
  logic [2:0]  alu_con_sig;
  logic        busy;
  logic [31:0] prod;

`ifdef ALU_DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_hi(resp_hi), .resp_err(resp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_con_sig(alu_con_sig),
    .alu_out(alu_out), .alu_hi(alu_hi), .alu_lo(alu_lo), .busy(busy)
  );

  // Behavioural shared ALU; illegal ops return a marker the DUT must ignore.
  always_comb begin
    prod    = {16'h0, alu_in1} * {16'h0, alu_in2};
    alu_hi  = prod[31:16];
    alu_lo  = prod[15:0];
    alu_out = 16'hDEAD;
    case (alu_con_sig)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_MUL:  alu_out = prod[15:0];
      OP_DIV:  alu_out = (alu_in2 == 16'h0) ? 16'hFFFF : alu_in1 / alu_in2;
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      default: alu_out = 16'hDEAD;
    endcase
  end

  typedef struct { logic id; logic [15:0] result; logic [15:0] hi; logic err; } resp_t;
  typedef struct { logic [2:0] op; logic [15:0] a; logic [15:0] b; } req_t;

  resp_t exp_q[$];
  req_t  pend0[$], pend1[$];
  int    grant_log[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic expect_resp(input logic id, input logic [15:0] r, input logic [15:0] h, input logic e);
    resp_t t;
    t.id = id; t.result = r; t.hi = h; t.err = e;
    exp_q.push_back(t);
  endtask

  task automatic add_req(input int who, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_t t;
    t.op = op; t.a = a; t.b = b;
    if (who == 0) pend0.push_back(t);
    else          pend1.push_back(t);
  endtask

  // Presents queued ops; returns #1 after the edge that accepted the last one.
  task automatic run_ops();
    int   cyc = 0;
    logic r0, r1;
    while ((pend0.size() > 0 || pend1.size() > 0) && cyc < 100) begin
      req0_valid = (pend0.size() > 0);
      if (req0_valid) begin req0_op = pend0[0].op; req0_a = pend0[0].a; req0_b = pend0[0].b; end
      req1_valid = (pend1.size() > 0);
      if (req1_valid) begin req1_op = pend1[0].op; req1_a = pend1[0].a; req1_b = pend1[0].b; end
      @(negedge clk);
      r0 = req0_valid && req0_ready;
      r1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (r0) begin void'(pend0.pop_front()); grant_log.push_back(0); end
      if (r1) begin void'(pend1.pop_front()); grant_log.push_back(1); end
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (cyc >= 100) begin
      fail_now("request_accept_timeout");
      pend0.delete();
      pend1.delete();
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 60) begin @(posedge clk); c++; end
    #1;
    if (exp_q.size() > 0) begin
      fail_now("response_drain_timeout");
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every completed response handshake is checked against the queue head.
  always @(negedge clk) begin : monitor
    resp_t e;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_response");
      else begin
        e = exp_q.pop_front();
        check("resp_id",     resp_id,     e.id);
        check("resp_result", resp_result, e.result);
        check("resp_hi",     resp_hi,     e.hi);
        check("resp_err",    resp_err,    e.err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_con", alu_con_sig, 0);
    rst = 1'b0;

    // 1: single add, latency and ALU drive during EXEC.
    expect_resp(0, 16'd8, 16'h0, 0);
    add_req(0, OP_ADD, 16'd3, 16'd5);
    run_ops();
    check("t1_valid_in_exec", resp_valid, 0);
    check("t1_busy", busy, 1);
    check("t1_alu_in1", alu_in1, 16'd3);
    check("t1_alu_in2", alu_in2, 16'd5);
    check("t1_alu_con", alu_con_sig, OP_ADD);
    @(posedge clk); #1;
    check("t1_valid_after_capture", resp_valid, 1);
    wait_drain();

    // 2: simultaneous requests from reset -> req0 first.
    do_reset();
    expect_resp(0, 16'd7, 16'h0, 0);
    expect_resp(1, 16'h00FF, 16'h0, 0);
    add_req(0, OP_SUB, 16'd10, 16'd3);
    add_req(1, OP_OR, 16'h00F0, 16'h000F);
    run_ops();
    wait_drain();

    // 3: multiply with a stalled consumer.
    resp_ready = 1'b0;
    expect_resp(0, 16'h3400, 16'h0012, 0);
    add_req(0, OP_MUL, 16'h1234, 16'h0100);
    run_ops();
    begin
      int c = 0;
      while (!resp_valid && c < 10) begin @(posedge clk); #1; c++; end
      if (!resp_valid) fail_now("t3_resp_valid_timeout");
    end
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'd2; req1_b = 16'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", resp_valid, 1);
      check("t3_hold_result", resp_result, 16'h3400);
      check("t3_hold_hi", resp_hi, 16'h0012);
      check("t3_hold_id", resp_id, 0);
      check("t3_no_accept0", req0_ready, 0);
      check("t3_no_accept1", req1_ready, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    wait_drain();

    // 4: illegal op, add wrap, normal divide, divide by zero.
    expect_resp(0, 16'h0000, 16'h0, 1);
    expect_resp(0, 16'h0001, 16'h0, 0);
    expect_resp(0, 16'd14, 16'h0, 0);
    add_req(0, 3'b111, 16'h1234, 16'h5678);
    add_req(0, OP_ADD, 16'hFFFF, 16'h0002);
    add_req(0, OP_DIV, 16'd100, 16'd7);
    run_ops();
    wait_drain();
    expect_resp(1, 16'hFFFF, 16'h0, TRAP);
    add_req(1, OP_DIV, 16'd7, 16'd0);
    run_ops();
    check("t4_div0_alu_in2", alu_in2, TRAP ? 16'd1 : 16'd0);
    wait_drain();

    // 6: reset during EXEC drops the op; the next one completes.
    add_req(0, OP_ADD, 16'd1, 16'd1);
    run_ops();
    check("t6_in_exec", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_resp(0, 16'h000A, 16'h0, 0);
    add_req(0, OP_AND, 16'h00AA, 16'h0F0F);
    run_ops();
    wait_drain();

    // 5: both requesters continuously valid -> alternating grants.
    do_reset();
    grant_log.delete();
    expect_resp(0, 16'd3, 16'h0, 0);
    expect_resp(1, 16'h000C, 16'h0, 0);
    expect_resp(0, 16'hFFFC, 16'h0, 0);
    expect_resp(1, 16'h000E, 16'h0, 0);
    expect_resp(0, 16'hF000, 16'h0, 0);
    expect_resp(1, 16'h1234, 16'h0, 0);
    add_req(0, OP_ADD, 16'd1, 16'd2);
    add_req(0, OP_SUB, 16'd5, 16'd9);
    add_req(0, OP_AND, 16'hF0F0, 16'hFF00);
    add_req(1, OP_MUL, 16'd3, 16'd4);
    add_req(1, OP_DIV, 16'd100, 16'd7);
    add_req(1, OP_OR, 16'h1200, 16'h0034);
    run_ops();
    wait_drain();
    check("t5_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t5_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : 99, i % 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
